// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone core-port arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  // One-hot {dport,iport} owner encoding as seen on grant_o.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Map the FSM state onto the one-hot grant vector.
  function automatic logic [1:0] state_to_grant(arb_state_t s);
    case (s)
      ARB_GRANT_I: state_to_grant = GNT_I;
      ARB_GRANT_D: state_to_grant = GNT_D;
      default:     state_to_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Granted-cycle counter: cleared while the arbiter is idle, counts granted
// cycles without ack, and flags expiry on the last allowed cycle.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count granted cycles; hold at the limit so the counter never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/wb_core_port_arbiter.sv
// 2:1 round-robin Wishbone classic arbiter: AtomRV iport (read-only) and
// dport share one memory port. Optional watchdog under ARB_TIMEOUT_EN.
//
// Handshake: a port requests with cyc&stb held high; the grant is taken on
// the next edge, the owner's signals drive m_* combinationally, and the
// transfer ends on the cycle m_ack_i is high (ack forwarded to the owner in
// that same cycle). Dropping cyc while granted aborts without an ack.
module wb_core_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  input  logic [ADDR_W-1:0] i_adr_i,
  output logic [DATA_W-1:0] i_dat_o,
  output logic              i_ack_o,
  output logic              i_err_o,
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [SEL_W-1:0]  d_sel_i,
  input  logic [ADDR_W-1:0] d_adr_i,
  input  logic [DATA_W-1:0] d_dat_i,
  output logic [DATA_W-1:0] d_dat_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [SEL_W-1:0]  m_sel_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [DATA_W-1:0] m_dat_o,
  input  logic [DATA_W-1:0] m_dat_i,
  input  logic              m_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o,
  output logic [1:0]        o_dbg_state
);

  arb_state_t r_state;
  logic       r_last_d;   // 1: dport was served last, so iport wins a tie
  logic       r_timeout;

  logic w_req_i, w_req_d;
  logic w_own_i, w_own_d;
  logic w_own_cyc, w_own_stb;
  logic w_expire, w_to_fire;

  assign w_req_i   = i_cyc_i & i_stb_i;
  assign w_req_d   = d_cyc_i & d_stb_i;
  assign w_own_i   = (r_state == ARB_GRANT_I);
  assign w_own_d   = (r_state == ARB_GRANT_D);
  assign w_own_cyc = (w_own_i & i_cyc_i) | (w_own_d & d_cyc_i);
  assign w_own_stb = (w_own_i & i_stb_i) | (w_own_d & d_stb_i);

`ifdef ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (sys_clk),
    .i_rst_n  (rst_n),
    .i_clear  (r_state == ARB_IDLE),
    .i_enable ((r_state != ARB_IDLE) & ~m_ack_i),
    .o_expire (w_expire)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_expire = 1'b0;
`endif

  // A same-cycle ack always beats the watchdog.
  assign w_to_fire = w_own_cyc & w_expire & ~m_ack_i;

  // Shared-port mux; iport is read-only so it presents full selects and no data.
  assign m_cyc_o = w_own_cyc & ~w_to_fire;
  assign m_stb_o = w_own_cyc & w_own_stb & ~w_to_fire;
  assign m_we_o  = w_own_d & d_we_i;
  assign m_sel_o = w_own_d ? d_sel_i : (w_own_i ? {SEL_W{1'b1}} : {SEL_W{1'b0}});
  assign m_adr_o = w_own_d ? d_adr_i : (w_own_i ? i_adr_i : {ADDR_W{1'b0}});
  assign m_dat_o = w_own_d ? d_dat_i : {DATA_W{1'b0}};

  // Read data fans out to both ports; ack/err only reach the live owner.
  assign i_dat_o = m_dat_i;
  assign d_dat_o = m_dat_i;
  assign i_ack_o = w_own_i & i_cyc_i & m_ack_i;
  assign d_ack_o = w_own_d & d_cyc_i & m_ack_i;
  assign i_err_o = w_own_i & w_to_fire;
  assign d_err_o = w_own_d & w_to_fire;

  assign grant_o     = state_to_grant(r_state);
  assign timeout_o   = r_timeout;
  assign o_dbg_state = r_state;

  // Arbitration FSM with round-robin pointer and sticky timeout flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_last_d  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_to_fire) r_timeout <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (w_req_i && w_req_d) r_state <= r_last_d ? ARB_GRANT_I : ARB_GRANT_D;
          else if (w_req_d)       r_state <= ARB_GRANT_D;
          else if (w_req_i)       r_state <= ARB_GRANT_I;
        end
        ARB_GRANT_I: begin
          if (!i_cyc_i) begin
            r_state <= ARB_IDLE;
          end else if (m_ack_i) begin
            r_state  <= ARB_IDLE;
            r_last_d <= 1'b0;
          end else if (w_to_fire) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_GRANT_D: begin
          if (!d_cyc_i) begin
            r_state <= ARB_IDLE;
          end else if (m_ack_i) begin
            r_state  <= ARB_IDLE;
            r_last_d <= 1'b1;
          end else if (w_to_fire) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
